not_32: RTL and testbench
=========================

# not_32

Registered 32-bit bitwise-NOT unit of the ALU in the 374 RISC processor datapath. It inverts operand `x`, ignores operand `y`, and writes a 64-bit result split across `Zlow` and `Zhigh`, matching the Z-register format shared by all ALU units. It adds a one-cycle valid handshake and optional result flags so the control unit can sequence it like the other ALU units.

## Interface
Parameters:
- none (width fixed at 32).

Ports:
- `clock`  input  1  rising-edge clock; one clock domain.
- `clear`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands valid; starts one operation this cycle.
- `x`  input  32  operand to invert.
- `y`  input  32  second ALU operand; unused by this unit, present for uniform ALU port list.
- `Zlow`  output  32  low result word, registered.
- `Zhigh`  output  32  high result word, registered; always 0 for NOT.
- `out_valid`  output  1  one-cycle pulse, result registers updated this cycle.
- `zero_flag`  output  1  result is all zeros (only with `NOT_32_FLAGS_EN`).
- `neg_flag`  output  1  result bit 31 (only with `NOT_32_FLAGS_EN`).
- `ones_count`  output  6  number of 1 bits in `Zlow`, 0..32 (only with `NOT_32_FLAGS_EN`).

Clock is `clock`. Reset is `clear`, synchronous and active-high.

## Operation
- On each rising edge of `clock`:
  - If `clear` is 1, all outputs go to 0. This includes `Zlow`, `Zhigh`, `out_valid` and the flags.
  - Otherwise, if `in_valid` is 1, the unit loads `Zlow <= ~x` and `Zhigh <= 32'h0`, and sets `out_valid <= 1`.
  - Otherwise, `out_valid <= 0`. `Zlow`, `Zhigh` and the flags hold their values.
- `y` never affects any output, for any value.
- Flags are computed from `~x` and registered on the same edge as `Zlow`:
  - `zero_flag = (~x == 0)`.
  - `neg_flag = ~x[31]`.
  - `ones_count = popcount(~x)`, which equals 32 − popcount(x).
- There is no internal state beyond the output registers. There is no FSM and no backpressure.

## Timing
- Latency: exactly 1 cycle from the edge at which `in_valid=1` is sampled to the same edge's registered outputs. `out_valid` is high during the following cycle.
- Throughput: one operation per cycle. Back-to-back `in_valid` gives back-to-back `out_valid` with per-cycle results.
- Reset value of every output: 0. The flags also reset to 0, even though ~0 would yield different values.
- `clear` and `in_valid` high in the same cycle: `clear` wins and the operation is dropped.
- `clear` asserted between operations: previous results are lost and `out_valid` stays 0 until the next accepted `in_valid`.
- Changes on `x` or `y` while `in_valid=0` have no effect on outputs.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `NOT_32_FLAGS_EN`.
- Defined: the flag logic is built. `zero_flag`, `neg_flag` and `ones_count` are registered as described above.
- Undefined: the flag logic is not built. The flag ports remain in the port list and are tied to constant 0. `Zlow`, `Zhigh` and `out_valid` behave identically in both builds.

## Test plan
- `clear=1` for 2 cycles, then `clear=0` with `in_valid=0` -> all outputs 0, `out_valid=0`.
- `y=32'hAAAAAAAA` held throughout; `in_valid=1` with `x=32'h55555555` -> next cycle:
  - `Zlow=32'hAAAAAAAA`, `Zhigh=0`, `out_valid=1`.
  - With flags: `neg_flag=1`, `zero_flag=0`, `ones_count=16`.
- Back-to-back inputs on consecutive cycles, `x=32'h0000FFFF`, then `32'hAAAAAAAA`, then `32'h00000001` -> consecutive outputs:
  - `Zlow=32'hFFFF0000` (with flags: `neg_flag=1`, `ones_count=16`).
  - Then `Zlow=32'h55555555` (with flags: `neg_flag=0`, `ones_count=16`).
  - Then `Zlow=32'hFFFFFFFE` (with flags: `ones_count=31`).
  - `out_valid` stays high for all 3 cycles.
- `x=32'hFFFFFFFF` -> `Zlow=0`; with flags, `zero_flag=1`, `ones_count=0`, `neg_flag=0`. `x=0` -> `Zlow=32'hFFFFFFFF`, `ones_count=32`.
- Hold: after a result, drive `in_valid=0` and toggle `x` and `y` -> `Zlow` is unchanged and `out_valid=0`. Vary `y` with fixed `x` -> identical results.
- `clear=1` together with `in_valid=1`, `x=32'h12345678` -> next cycle all outputs 0 and `out_valid=0`. Repeat in a build without `NOT_32_FLAGS_EN` -> flags are always 0 and the data path is unchanged.

Source files
------------

// File: rtl/not_32.sv
// ============================================================================
//  Module   : not_32
//  Function : Registered 32-bit bitwise-NOT ALU unit writing the 64-bit Z pair,
//             with a one-cycle valid pulse. Optional result flags are built
//             when the macro NOT_32_FLAGS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module not_32 (
   input  logic        clock,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [31:0] Zlow,
   output logic [31:0] Zhigh,
   output logic        out_valid,
   output logic        zero_flag,
   output logic        neg_flag,
   output logic [5:0]  ones_count
);

   logic [31:0] w_not_x;
   logic [31:0] r_zlow;
   logic [31:0] r_zhigh;
   logic        r_out_valid;

   // y exists only so every ALU unit shares one port list
   logic        w_unused_y;
   assign w_unused_y = ^y;

   assign w_not_x = ~x;

   always_ff @(posedge clock) begin
      if (clear) begin
         r_zlow      <= 32'h0;
         r_zhigh     <= 32'h0;
         r_out_valid <= 1'b0;
      end else if (in_valid) begin
         r_zlow      <= w_not_x;
         r_zhigh     <= 32'h0;
         r_out_valid <= 1'b1;
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign Zlow      = r_zlow;
   assign Zhigh     = r_zhigh;
   assign out_valid = r_out_valid;

`ifdef NOT_32_FLAGS_EN
   logic [5:0] w_ones;
   logic       r_zero_flag;
   logic       r_neg_flag;
   logic [5:0] r_ones_count;

   always_comb begin
      w_ones = 6'd0;
      for (int i = 0; i < 32; i++) begin
         w_ones = w_ones + {5'd0, w_not_x[i]};
      end
   end

   // Flags reset to 0 rather than to the values ~0 would produce
   always_ff @(posedge clock) begin
      if (clear) begin
         r_zero_flag  <= 1'b0;
         r_neg_flag   <= 1'b0;
         r_ones_count <= 6'd0;
      end else if (in_valid) begin
         r_zero_flag  <= (w_not_x == 32'h0);
         r_neg_flag   <= w_not_x[31];
         r_ones_count <= w_ones;
      end
   end

   assign zero_flag  = r_zero_flag;
   assign neg_flag   = r_neg_flag;
   assign ones_count = r_ones_count;
`else
   assign zero_flag  = 1'b0;
   assign neg_flag   = 1'b0;
   assign ones_count = 6'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_not_32.sv
// ============================================================================
//  Module   : tb_not_32
//  Function : Self-checking bench for not_32 (vector table plus scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_not_32;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] x = 32'h0;
   logic [31:0] y = 32'h0;
   logic [31:0] Zlow;
   logic [31:0] Zhigh;
   logic        out_valid;
   logic        zero_flag;
   logic        neg_flag;
   logic [5:0]  ones_count;

`ifdef NOT_32_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   not_32 dut (
      .clock      (clock),
      .clear      (clear),
      .in_valid   (in_valid),
      .x          (x),
      .y          (y),
      .Zlow       (Zlow),
      .Zhigh      (Zhigh),
      .out_valid  (out_valid),
      .zero_flag  (zero_flag),
      .neg_flag   (neg_flag),
      .ones_count (ones_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] zlow;
      logic        zero;
      logic        neg;
      logic [5:0]  ones;
      logic        valid;
      int          tgt;
   } exp_t;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] zlow;
      logic        zero;
      logic        neg;
      logic [5:0]  ones;
   } vec_t;

   exp_t q[$];
   exp_t last;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Scoreboard: compare the oldest entry once its target cycle arrives
   always @(negedge clock) begin
      if (q.size() > 0 && q[0].tgt == cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("Zlow",       Zlow,                e.zlow);
         chk("Zhigh",      Zhigh,               32'h0);
         chk("out_valid",  {31'd0, out_valid},  {31'd0, e.valid});
         chk("zero_flag",  {31'd0, zero_flag},  {31'd0, e.zero});
         chk("neg_flag",   {31'd0, neg_flag},   {31'd0, e.neg});
         chk("ones_count", {26'd0, ones_count}, {26'd0, e.ones});
      end
   end

   // Reference behaviour: result holds unless cleared or loaded
   function automatic exp_t predict(input bit clr, input bit iv, input logic [31:0] xv);
      exp_t e;
      e = last;
      e.valid = 1'b0;
      if (clr) begin
         e.zlow = 32'h0;
         e.zero = 1'b0;
         e.neg  = 1'b0;
         e.ones = 6'd0;
      end else if (iv) begin
         e.zlow  = ~xv;
         e.zero  = FL & (xv == 32'hFFFF_FFFF);
         e.neg   = FL & ~xv[31];
         e.ones  = FL ? 6'(32 - $countones(xv)) : 6'd0;
         e.valid = 1'b1;
      end
      return e;
   endfunction

   task automatic drive(input bit clr, input bit iv, input logic [31:0] xv,
                        input logic [31:0] yv, input exp_t e);
      @(posedge clock);
      #2;
      clear    = clr;
      in_valid = iv;
      x        = xv;
      y        = yv;
      e.tgt    = cyc + 1;
      q.push_back(e);
      last     = e;
   endtask

   task automatic step(input bit clr, input bit iv, input logic [31:0] xv, input logic [31:0] yv);
      drive(clr, iv, xv, yv, predict(clr, iv, xv));
   endtask

   vec_t tab[8];

   initial begin
      exp_t e;
      tab[0] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 1'b1, 6'd16};
      tab[1] = '{32'h0000_FFFF, 32'hAAAA_AAAA, 32'hFFFF_0000, 1'b0, 1'b1, 6'd16};
      tab[2] = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 6'd16};
      tab[3] = '{32'h0000_0001, 32'hAAAA_AAAA, 32'hFFFF_FFFE, 1'b0, 1'b1, 6'd31};
      tab[4] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1, 1'b0, 6'd0};
      tab[5] = '{32'h0000_0000, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 1'b1, 6'd32};
      tab[6] = '{32'h1234_5678, 32'hAAAA_AAAA, 32'hEDCB_A987, 1'b0, 1'b1, 6'd19};
      tab[7] = '{32'h8000_0000, 32'hAAAA_AAAA, 32'h7FFF_FFFF, 1'b0, 1'b0, 6'd31};

      last = '{32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 0};

      // Reset, then idle: everything zero
      step(1'b1, 1'b0, 32'h0, 32'hAAAA_AAAA);
      step(1'b1, 1'b0, 32'h0, 32'hAAAA_AAAA);
      step(1'b0, 1'b0, 32'h0, 32'hAAAA_AAAA);
      step(1'b0, 1'b0, 32'h0, 32'hAAAA_AAAA);

      // Back-to-back table vectors
      foreach (tab[i]) begin
         e.zlow  = tab[i].zlow;
         e.zero  = FL & tab[i].zero;
         e.neg   = FL & tab[i].neg;
         e.ones  = FL ? tab[i].ones : 6'd0;
         e.valid = 1'b1;
         e.tgt   = 0;
         drive(1'b0, 1'b1, tab[i].x, tab[i].y, e);
      end

      // Hold: idle with toggling operands
      step(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_0000);
      step(1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

      // y must not matter
      step(1'b0, 1'b1, 32'h0F0F_0F0F, 32'h0000_0000);
      step(1'b0, 1'b1, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 32'h0F0F_0F0F, $urandom);

      // clear wins over in_valid
      step(1'b1, 1'b1, 32'h1234_5678, 32'hAAAA_AAAA);
      step(1'b0, 1'b0, 32'h1234_5678, 32'hAAAA_AAAA);

      // Result lost across a clear between operations
      step(1'b0, 1'b1, 32'h00FF_00FF, 32'h0);
      step(1'b0, 1'b0, 32'h00FF_00FF, 32'h0);
      step(1'b1, 1'b0, 32'h00FF_00FF, 32'h0);
      step(1'b0, 1'b0, 32'h00FF_00FF, 32'h0);

      // Random mix of loads and idles
      for (int k = 0; k < 24; k++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0);

      for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
